// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the byte FIFO and the UART transmitter.
// master = transmitter side, slave = FIFO/line side.
interface fifo_uart_tx_if;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        input  tx_en, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, frame_done
    );

    modport slave (
        output tx_en, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and sends them as 8N1 UART frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic            clk,
    input logic            rstn,
    fifo_uart_tx_if.master bus
);
    // IDLE: wait/pop | LOAD: latch byte | START | DATA: lsb first | PARITY (opt) | STOP
    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  BAUD_ONE  = CW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_bit_done;
    logic          w_rd_en;
    logic          w_frame_done;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    assign w_bit_done = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = w_bit_done ? '0 : r_baud + BAUD_ONE;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        w_rd_en       = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt    = '0;
                w_bit_idx_nxt = 3'd0;
                // Gated by rstn so no pop strobe leaks out while reset is held.
                if (rstn && bus.tx_en && !bus.fifo_empty) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_baud_nxt  = '0;
                w_shreg_nxt = bus.fifo_data;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_done) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_shreg_nxt   = r_shreg >> 1;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line level is registered from the next state so tx is glitch-free.
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = r_parity;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shreg   <= w_shreg_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  r_parity <= 1'b0;
        else if (r_state == S_LOAD) r_parity <= ^bus.fifo_data;
    end
`endif

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = w_frame_done;

endmodule
